video_src_gen: RTL and testbench

- Synthesizable multi-channel video source. Generates hblank/vblank/active_video/video_data framing plus a deterministic test pattern for CHANNEL_NUM parallel channels.
- Drives the input side of data_com, acting as its transmitter. Used in FPGA self-test and as the stimulus source in block benches.
- All channels are driven in lockstep: identical timing, with per-channel pattern data.

---
 rtl/video_src_gen.sv | 216 +++++++++++++++++++++
 tb/tb_video_src_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_src_gen.sv
// Multi-channel video test-pattern source.
// A timing FSM walks through vblank lines, then active lines, one column per
// enabled cycle. A registered output stage turns that position into
// hblank/vblank/active framing and per-channel pattern data. The outputs
// therefore trail the FSM by one clock.
module video_src_gen #(
  parameter int CHANNEL_NUM      = 2,
  parameter int VIDEO_DATA_WIDTH = 30,
  parameter int TIMING_CNT_WIDTH = 11,
  parameter int FRAME_CNT_WIDTH  = 8
) (
  input  logic                                    clk,
  input  logic                                    sclr,
  input  logic                                    ce,
  input  logic                                    start,
  input  logic [FRAME_CNT_WIDTH-1:0]              frame_num,
  input  logic [TIMING_CNT_WIDTH-1:0]             col_max,
  input  logic [TIMING_CNT_WIDTH-1:0]             row_max,
  input  logic [TIMING_CNT_WIDTH-1:0]             h_blank_len,
  input  logic [TIMING_CNT_WIDTH-1:0]             v_blank_len,
  input  logic [1:0]                              pattern_sel,
  input  logic                                    stop,
  output logic [CHANNEL_NUM-1:0]                  hblank_out,
  output logic [CHANNEL_NUM-1:0]                  vblank_out,
  output logic [CHANNEL_NUM-1:0]                  active_video_out,
  output logic [CHANNEL_NUM*VIDEO_DATA_WIDTH-1:0] video_data_out,
  output logic                                    busy,
  output logic                                    frame_done
);

  localparam int C  = CHANNEL_NUM;
  localparam int W  = VIDEO_DATA_WIDTH;
  localparam int T  = TIMING_CNT_WIDTH;
  localparam int F  = FRAME_CNT_WIDTH;
  // One extra bit: a full line (col_max + hblank) can exceed 2^T - 1.
  localparam int LW = T + 1;
  // Wide enough that the pattern arithmetic never overflows before truncation.
  localparam int PW = 2*T + F + 32;

  typedef enum logic [1:0] {IDLE, VBLK, ACT} state_t;

  state_t         state_q, state_d;
  logic [LW-1:0]  col_q, col_d;
  logic [T-1:0]   row_q, row_d;
  logic [F-1:0]   frm_q, frm_d;
  logic           stop_seen_q, stop_seen_d;

  // Configuration captured on an accepted start.
  logic [T-1:0]   col_max_q, row_max_q, vbl_q;
  logic [LW-1:0]  line_end_q;
  logic [F-1:0]   frame_num_q;
  logic [1:0]     pat_q;
  logic           cfg_load;
  logic [T-1:0]   hbl_eff;
  logic [LW-1:0]  line_end_d;

  logic [C-1:0]   hblank_q, hblank_d;
  logic [C-1:0]   vblank_q, vblank_d;
  logic [C-1:0]   active_q, active_d;
  logic [C*W-1:0] data_q, data_d;
  logic           busy_q, busy_d;
  logic           frame_done_q, frame_done_d;

  logic           line_last;
  logic           pix_win;
  logic           last_row;
  logic           start_ok;

  // Pattern value for channel k at the given position.
  function automatic logic [W-1:0] pattern_val(input logic [1:0]    sel,
                                               input logic [PW-1:0] k,
                                               input logic [T-1:0]  col,
                                               input logic [T-1:0]  row,
                                               input logic [T-1:0]  cmax,
                                               input logic [F-1:0]  frm);
    logic [PW-1:0] wide;
    case (sel)
      2'd0:    wide = k * PW'(cmax) + PW'(col);
      2'd1:    wide = PW'({row, col});
      2'd2:    wide = k + PW'(1);
      default: wide = PW'(frm);
    endcase
    return W'(wide);
  endfunction

  assign line_last = (col_q == line_end_q);
  assign pix_win   = (col_q < {1'b0, col_max_q});
  assign last_row  = (row_q == row_max_q - T'(1));
  assign start_ok  = start && (col_max != '0) && (row_max != '0);
  assign hbl_eff   = (h_blank_len == '0) ? T'(1) : h_blank_len;
  assign line_end_d = {1'b0, col_max} + {1'b0, hbl_eff} - LW'(1);

  // Next-state logic: column/line/frame counting and frame sequencing.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    frm_d       = frm_q;
    stop_seen_d = stop_seen_q;
    cfg_load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          cfg_load    = 1'b1;
          col_d       = '0;
          row_d       = '0;
          frm_d       = '0;
          stop_seen_d = 1'b0;
          state_d     = (v_blank_len != '0) ? VBLK : ACT;
        end
      end
      VBLK: begin
        stop_seen_d = stop_seen_q | stop;
        if (line_last) begin
          col_d = '0;
          if (row_q == vbl_q - T'(1)) begin
            row_d   = '0;
            state_d = ACT;
          end else begin
            row_d = row_q + T'(1);
          end
        end else begin
          col_d = col_q + LW'(1);
        end
      end
      ACT: begin
        stop_seen_d = stop_seen_q | stop;
        if (line_last) begin
          col_d = '0;
          if (last_row) begin
            row_d = '0;
            frm_d = frm_q + F'(1);
            if (((frame_num_q != '0) && (frm_q + F'(1) == frame_num_q)) ||
                stop_seen_q || stop) begin
              state_d = IDLE;
            end else begin
              // Stop only applies to frames that start after it is seen.
              stop_seen_d = 1'b0;
              state_d     = (vbl_q != '0) ? VBLK : ACT;
            end
          end else begin
            row_d = row_q + T'(1);
          end
        end else begin
          col_d = col_q + LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current FSM position; registered below.
  always_comb begin
    busy_d       = (state_q != IDLE);
    hblank_d     = {C{~(busy_d && pix_win)}};
    vblank_d     = {C{state_q != ACT}};
    active_d     = {C{(state_q == ACT) && pix_win}};
    frame_done_d = (state_q == ACT) && line_last && last_row;
    data_d       = '0;
    for (int k = 0; k < C; k++) begin
      if ((state_q == ACT) && pix_win) begin
        data_d[k*W +: W] = pattern_val(pat_q, PW'(k), col_q[T-1:0], row_q,
                                       col_max_q, frm_q);
      end
    end
  end

  // FSM, counters and output registers; sclr overrides ce.
  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      frm_q        <= '0;
      stop_seen_q  <= 1'b0;
      hblank_q     <= '1;
      vblank_q     <= '1;
      active_q     <= '0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (ce) begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      frm_q        <= frm_d;
      stop_seen_q  <= stop_seen_d;
      hblank_q     <= hblank_d;
      vblank_q     <= vblank_d;
      active_q     <= active_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Configuration snapshot; only meaningful while busy, so it needs no reset.
  always_ff @(posedge clk) begin
    if (ce && !sclr && cfg_load) begin
      col_max_q   <= col_max;
      row_max_q   <= row_max;
      vbl_q       <= v_blank_len;
      line_end_q  <= line_end_d;
      frame_num_q <= frame_num;
      pat_q       <= pattern_sel;
    end
  end

  assign hblank_out       = hblank_q;
  assign vblank_out       = vblank_q;
  assign active_video_out = active_q;
  assign video_data_out   = data_q;
  assign busy             = busy_q;
  assign frame_done       = frame_done_q;

endmodule

// File: tb/tb_video_src_gen.sv
// Bench for video_src_gen: a table of configurations with hand-computed
// cycle counts, plus a monitor that tracks row/col/frame from the framing
// signals and checks every active pixel against the pattern definitions.
module tb_video_src_gen;

  localparam int C = 2;
  localparam int W = 30;
  localparam int T = 11;
  localparam int F = 8;

  logic           clk = 1'b0;
  logic           sclr, ce, start, stop;
  logic [F-1:0]   frame_num;
  logic [T-1:0]   col_max, row_max, h_blank_len, v_blank_len;
  logic [1:0]     pattern_sel;
  logic [C-1:0]   hblank_out, vblank_out, active_video_out;
  logic [C*W-1:0] video_data_out;
  logic           busy, frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  video_src_gen #(
    .CHANNEL_NUM(C), .VIDEO_DATA_WIDTH(W),
    .TIMING_CNT_WIDTH(T), .FRAME_CNT_WIDTH(F)
  ) dut (
    .clk(clk), .sclr(sclr), .ce(ce), .start(start),
    .frame_num(frame_num), .col_max(col_max), .row_max(row_max),
    .h_blank_len(h_blank_len), .v_blank_len(v_blank_len),
    .pattern_sel(pattern_sel), .stop(stop),
    .hblank_out(hblank_out), .vblank_out(vblank_out),
    .active_video_out(active_video_out), .video_data_out(video_data_out),
    .busy(busy), .frame_done(frame_done)
  );

  typedef struct {
    int col, row, hbl, vbl, fn, pat;
    int sws;          // stop asserted together with start
    int stop_at;      // busy-cycle index for a stop pulse (-1 none)
    int restart_at;   // busy-cycle index for a start pulse + col_max change
    int gap_at;       // busy-cycle index after which ce drops for 7 cycles
    int sclr_at;      // busy-cycle index at which sclr is pulsed
    int e_busy, e_act, e_vbl, e_hbl, e_fd;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] exp_pix(int k, int pat, int cm, int row,
                                           int col, int frm);
    case (pat)
      0:       return W'(k * cm + col);
      1:       return W'((row << T) | col);
      2:       return W'(k + 1);
      default: return W'(frm % 256);
    endcase
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_hblank"}, hblank_out, 3);
    check({tag, "_vblank"}, vblank_out, 3);
    check({tag, "_active"}, active_video_out, 0);
    check({tag, "_data"}, video_data_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  task automatic run(input vec_t v, input int idx);
    int cyc, n_busy, n_act, n_vbl, n_hbl, n_fd, n_bad, n_hold_bad;
    int col_m, row_m, frm_m;
    logic last_fd, aborted;
    logic [C*W-1:0] s_d;
    logic [C-1:0] s_h, s_v, s_a;
    logic s_b, s_f;
    string tag;
    tag = $sformatf("v%0d", idx);
    cyc = 0; n_busy = 0; n_act = 0; n_vbl = 0; n_hbl = 0; n_fd = 0;
    n_bad = 0; n_hold_bad = 0; col_m = 0; row_m = 0; frm_m = 0;
    last_fd = 1'b0; aborted = 1'b0;
    col_max     = T'(v.col);
    row_max     = T'(v.row);
    h_blank_len = T'(v.hbl);
    v_blank_len = T'(v.vbl);
    frame_num   = F'(v.fn);
    pattern_sel = 2'(v.pat);
    start = 1'b1;
    stop  = (v.sws != 0);
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check({tag, "_busy_at_t"}, busy, 0);
    tick();
    if (v.e_busy == 0) begin
      check({tag, "_illegal_busy"}, busy, 0);
      tick(); tick();
      check({tag, "_illegal_busy_later"}, busy, 0);
      check({tag, "_illegal_vblank"}, vblank_out, 3);
      return;
    end
    check({tag, "_first_busy"}, busy, 1);
    check({tag, "_first_vblank"}, vblank_out, (v.vbl != 0) ? 3 : 0);
    check({tag, "_first_active"}, active_video_out, (v.vbl == 0) ? 3 : 0);
    while (busy === 1'b1 && cyc < 20000) begin
      n_busy++;
      if (hblank_out !== 2'b00 && hblank_out !== 2'b11) n_bad++;
      if (vblank_out !== 2'b00 && vblank_out !== 2'b11) n_bad++;
      if (active_video_out !== 2'b00 && active_video_out !== 2'b11) n_bad++;
      if (hblank_out[0]) n_hbl++;
      if (vblank_out[0]) n_vbl++;
      if (active_video_out[0]) begin
        n_act++;
        if (hblank_out[0] || vblank_out[0]) n_bad++;
        for (int k = 0; k < C; k++)
          if (video_data_out[k*W +: W] !== exp_pix(k, v.pat, v.col, row_m, col_m, frm_m))
            n_bad++;
        col_m++;
      end else begin
        if (video_data_out !== '0) n_bad++;
        if (col_m != 0) begin
          row_m++;
          col_m = 0;
        end
      end
      last_fd = frame_done;
      if (frame_done) begin
        n_fd++;
        row_m = 0;
        frm_m++;
      end
      start = 1'b0;
      stop  = 1'b0;
      if (cyc == v.stop_at) stop = 1'b1;
      if (cyc == v.restart_at) begin
        start   = 1'b1;
        col_max = T'(7);
      end
      if (cyc == v.sclr_at) begin
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        check_idle_outputs({tag, "_sclr"});
        aborted = 1'b1;
        break;
      end
      if (cyc == v.gap_at) begin
        s_d = video_data_out; s_h = hblank_out; s_v = vblank_out;
        s_a = active_video_out; s_b = busy; s_f = frame_done;
        ce = 1'b0;
        repeat (7) begin
          tick();
          if (video_data_out !== s_d || hblank_out !== s_h || vblank_out !== s_v ||
              active_video_out !== s_a || busy !== s_b || frame_done !== s_f)
            n_hold_bad++;
        end
        ce = 1'b1;
        check({tag, "_ce_hold"}, n_hold_bad, 0);
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    stop  = 1'b0;
    if (!aborted) begin
      check({tag, "_no_timeout"}, (cyc < 20000), 1);
      check({tag, "_busy_cycles"}, n_busy, v.e_busy);
      check({tag, "_active_cycles"}, n_act, v.e_act);
      check({tag, "_vblank_cycles"}, n_vbl, v.e_vbl);
      check({tag, "_hblank_cycles"}, n_hbl, v.e_hbl);
      check({tag, "_frame_done_count"}, n_fd, v.e_fd);
      check({tag, "_framing_and_data"}, n_bad, 0);
      check({tag, "_done_on_last_cycle"}, last_fd, 1);
      check_idle_outputs({tag, "_end"});
    end
  endtask

  vec_t tbl[10];

  initial begin
    //          col row hbl vbl fn pat sws stop rst gap sclr busy  act  vbl  hbl fd
    tbl[0] = '{100, 40, 20, 2, 1, 0,  0,  -1, -1, -1,  -1, 5040, 4000, 240, 840, 1};
    tbl[1] = '{  4,  3,  0, 0, 3, 3,  0,  -1, -1, -1,  -1,   45,   36,   0,   9, 3};
    tbl[2] = '{  5,  2,  3, 1, 2, 1,  0,  -1, 10, -1,  -1,   48,   20,  16,  18, 2};
    tbl[3] = '{  3,  2,  2, 0, 2, 2,  1,  -1, -1, -1,  -1,   20,   12,   0,   8, 2};
    tbl[4] = '{ 10,  2,  4, 1, 1, 0,  0,  -1, -1, 20,  -1,   42,   20,  14,  12, 1};
    tbl[5] = '{  3,  2,  1, 1, 0, 3,  0,  17, -1, -1,  -1,   24,   12,   8,   6, 2};
    tbl[6] = '{  0,  5,  2, 1, 1, 0,  0,  -1, -1, -1,  -1,    0,    0,   0,   0, 0};
    tbl[7] = '{  5,  0,  2, 1, 1, 0,  0,  -1, -1, -1,  -1,    0,    0,   0,   0, 0};
    tbl[8] = '{  8, 12,  2, 0, 1, 1,  0,  -1, -1, -1, 103,    0,    0,   0,   0, 0};
    tbl[9] = '{  8, 12,  2, 0, 1, 1,  0,  -1, -1, -1,  -1,  120,   96,   0,  24, 1};

    sclr = 1'b1; ce = 1'b1; start = 1'b0; stop = 1'b0;
    frame_num = '0; col_max = '0; row_max = '0;
    h_blank_len = '0; v_blank_len = '0; pattern_sel = '0;
    tick();
    tick();
    check_idle_outputs("reset");
    sclr = 1'b0;
    tick();
    check_idle_outputs("idle_after_reset");

    for (int i = 0; i < 10; i++) begin
      // Config row 8 has nonzero sizes but must abort via sclr, so its
      // expected busy count is a don't-care; give it a nonzero marker.
      if (i == 8) tbl[i].e_busy = 1;
      run(tbl[i], i);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
